parse_ctrl: RTL and testbench

Instruction sequencer for the parsing datapath. Fetches one byte-coded micro-instruction per step from program memory over a req/ack handshake. Decodes bits [7:5] into one-cycle control strobes (VAR/OP/HI write enables and mux selects) for the parsing block. Owns the A/B bank-select `cycle` bit, so it is the sole driver of all parsing control inputs.

---
 rtl/parse_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_parse_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/parse_ctrl.sv
// parse_ctrl: instruction sequencer for the parsing datapath.
// Fetches one byte-coded micro-instruction per step over a req/ack
// handshake, decodes in_mem[7:5] into registered one-cycle strobes for the
// parsing block, and owns the A/B bank-select bit `cycle`.
// Optional feature macro: PARSE_CTRL_WATCHDOG_EN adds a FETCH timeout that
// raises err and returns to IDLE after 16 cycles without mem_ack.

module parse_ctrl #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] PC_START = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        in_mem,
    output logic              cycle,
    output logic              flag_b,
    output logic              mux_hi,
    output logic [1:0]        mux_var,
    output logic              en_op,
    output logic              en_var3,
    output logic              en_d4,
    output logic              en_hi,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_NIB   = 3'b001;
    localparam logic [2:0] OP_OFFS  = 3'b010;
    localparam logic [2:0] OP_STATE = 3'b011;
    localparam logic [2:0] OP_HIV   = 3'b100;
    localparam logic [2:0] OP_HIS   = 3'b101;
    localparam logic [2:0] OP_SWAP  = 3'b110;
    localparam logic [2:0] OP_END   = 3'b111;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic              cycle_next;
    logic              err_next;
    logic [2:0]        exec_op;
    logic [2:0]        fetch_op;
    logic              accept;
    logic              wd_expire;

    logic              flag_b_d;
    logic              mux_hi_d;
    logic [1:0]        mux_var_d;
    logic              en_op_d;
    logic              en_var3_d;
    logic              en_d4_d;
    logic              en_hi_d;
    logic              done_d;

    // An instruction is taken only while fetching, and abort always wins.
    assign fetch_op = in_mem[7:5];
    assign accept   = (state == FETCH) && mem_ack && !abort;

    // Handshake and status are pure functions of registered state, so an
    // async reset forces them to their idle values immediately.
    assign mem_req  = (state == FETCH);
    assign mem_addr = pc;
    assign busy     = (state != IDLE);

`ifdef PARSE_CTRL_WATCHDOG_EN
    logic [3:0] wd_cnt;

    // Count consecutive FETCH cycles; the count restarts from zero on each
    // entry to FETCH because it is held at zero everywhere else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= 4'd0;
        end else if (state != FETCH) begin
            wd_cnt <= 4'd0;
        end else begin
            wd_cnt <= wd_cnt + 4'd1;
        end
    end

    assign wd_expire = (state == FETCH) && !mem_ack && (wd_cnt == 4'hF);
`else
    assign wd_expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: abort overrides every other transition.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state_next = FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        state_next = EXEC;
                    end else if (wd_expire) begin
                        state_next = IDLE;
                    end
                end
                EXEC: begin
                    if (exec_op == OP_END) begin
                        state_next = IDLE;
                    end else begin
                        state_next = FETCH;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Output decode: strobe values to be registered for the EXEC cycle that
    // follows an accepted fetch; everything is zero in any other cycle.
    always_comb begin
        flag_b_d  = 1'b0;
        mux_hi_d  = 1'b0;
        mux_var_d = 2'b00;
        en_op_d   = 1'b0;
        en_var3_d = 1'b0;
        en_d4_d   = 1'b0;
        en_hi_d   = 1'b0;
        done_d    = 1'b0;
        if (accept) begin
            unique case (fetch_op)
                OP_LOAD: begin
                    en_op_d   = 1'b1;
                    en_var3_d = 1'b1;
                    en_d4_d   = 1'b1;
                    mux_var_d = 2'b00;
                end
                OP_NIB: begin
                    en_var3_d = 1'b1;
                    en_d4_d   = 1'b1;
                    mux_var_d = 2'b01;
                end
                OP_OFFS: begin
                    en_var3_d = 1'b1;
                    en_d4_d   = 1'b1;
                    mux_var_d = 2'b11;
                end
                OP_STATE: begin
                    en_var3_d = 1'b1;
                    en_d4_d   = 1'b1;
                    mux_var_d = 2'b10;
                    flag_b_d  = in_mem[4];
                end
                OP_HIV: begin
                    en_hi_d  = cycle;
                    mux_hi_d = 1'b0;
                end
                OP_HIS: begin
                    en_hi_d  = cycle;
                    mux_hi_d = 1'b1;
                end
                OP_SWAP: begin
                    done_d = 1'b0;
                end
                OP_END: begin
                    done_d = 1'b1;
                end
                default: begin
                    done_d = 1'b0;
                end
            endcase
        end
    end

    // Program counter, bank bit and sticky error updates; abort freezes all.
    always_comb begin
        pc_next    = pc;
        cycle_next = cycle;
        err_next   = err;
        if (!abort) begin
            if ((state == IDLE) && start) begin
                pc_next  = PC_START;
                err_next = 1'b0;
            end
            if (accept) begin
                pc_next = pc + 1'b1;
            end
            if ((state == EXEC) && (exec_op == OP_SWAP)) begin
                cycle_next = ~cycle;
            end
            if ((state == EXEC) && ((exec_op == OP_HIV) || (exec_op == OP_HIS))
                && !cycle) begin
                err_next = 1'b1;
            end
            if (wd_expire) begin
                err_next = 1'b1;
            end
        end
    end

    // Datapath registers: pc, bank bit, error flag, latched opcode, strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= '0;
            cycle   <= 1'b0;
            err     <= 1'b0;
            exec_op <= 3'b000;
            flag_b  <= 1'b0;
            mux_hi  <= 1'b0;
            mux_var <= 2'b00;
            en_op   <= 1'b0;
            en_var3 <= 1'b0;
            en_d4   <= 1'b0;
            en_hi   <= 1'b0;
            done    <= 1'b0;
        end else begin
            pc      <= pc_next;
            cycle   <= cycle_next;
            err     <= err_next;
            if (accept) begin
                exec_op <= fetch_op;
            end
            flag_b  <= flag_b_d;
            mux_hi  <= mux_hi_d;
            mux_var <= mux_var_d;
            en_op   <= en_op_d;
            en_var3 <= en_var3_d;
            en_d4   <= en_d4_d;
            en_hi   <= en_hi_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_parse_ctrl.sv
// Self-checking bench for parse_ctrl: directed programs plus random programs
// checked against an instruction-level reference model.
module tb_parse_ctrl;

    localparam int         ADDR_W   = 8;
    localparam logic [7:0] PC_START = 8'hFE;

    logic       clk = 1'b0;
    logic       reset, start, abort, mem_ack;
    logic [7:0] in_mem;
    logic       mem_req, cycle, flag_b, mux_hi;
    logic [7:0] mem_addr;
    logic [1:0] mux_var;
    logic       en_op, en_var3, en_d4, en_hi, busy, done, err;
    logic [7:0] strobes;

    int vectors     = 0;
    int miscompares = 0;

    logic       model_cycle;
    logic       model_err;
    logic [7:0] model_pc;
    logic [7:0] prog[$];

    parse_ctrl #(.ADDR_W(ADDR_W), .PC_START(PC_START)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .in_mem(in_mem), .cycle(cycle), .flag_b(flag_b), .mux_hi(mux_hi),
        .mux_var(mux_var), .en_op(en_op), .en_var3(en_var3), .en_d4(en_d4),
        .en_hi(en_hi), .busy(busy), .done(done), .err(err)
    );

    assign strobes = {flag_b, mux_hi, mux_var, en_op, en_var3, en_d4, en_hi};

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Expected strobe byte {flag_b, mux_hi, mux_var, en_op, en_var3, en_d4, en_hi}.
    function automatic logic [7:0] expStrobes(input logic [7:0] b, input logic cyc);
        logic [2:0] op;
        op = b[7:5];
        case (op)
            3'd0:    return 8'b0_0_00_1_1_1_0;
            3'd1:    return 8'b0_0_01_0_1_1_0;
            3'd2:    return 8'b0_0_11_0_1_1_0;
            3'd3:    return {b[4], 7'b0_10_0_1_1_0};
            3'd4:    return {7'b0_0_00_0_0_0, cyc};
            3'd5:    return {7'b0_1_00_0_0_0, cyc};
            default: return 8'h00;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Run the program in prog from PC_START with random fetch latencies.
    task automatic runProgram(input int waitMin, input int waitMax);
        int         waitCycles;
        logic [2:0] op;
        mem_ack = 1'($urandom_range(0, 1));
        in_mem  = 8'($urandom);
        tick;
        mem_ack = 1'b0;
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_req", mem_req, 0);
        start = 1'b1;
        tick;
        start = 1'b0;
        model_err = 1'b0;
        model_pc  = PC_START;
        foreach (prog[i]) begin
            waitCycles = $urandom_range(waitMax, waitMin);
            for (int w = 0; w <= waitCycles; w++) begin
                checkOutput("fetch_req", mem_req, 1);
                checkOutput("fetch_addr", mem_addr, model_pc);
                checkOutput("fetch_strobes", strobes, 0);
                checkOutput("fetch_done", done, 0);
                start   = ($urandom_range(0, 3) == 0);
                mem_ack = (w == waitCycles);
                in_mem  = mem_ack ? prog[i] : 8'($urandom);
                tick;
            end
            start   = 1'b0;
            mem_ack = 1'($urandom_range(0, 1));
            op      = prog[i][7:5];
            model_pc = model_pc + 8'd1;
            checkOutput("exec_strobes", strobes, expStrobes(prog[i], model_cycle));
            checkOutput("exec_done", done, (op == 3'b111));
            checkOutput("exec_req", mem_req, 0);
            checkOutput("exec_busy", busy, 1);
            checkOutput("exec_cycle", cycle, model_cycle);
            if (op == 3'b110) model_cycle = ~model_cycle;
            if ((op == 3'b100 || op == 3'b101) && !model_cycle) model_err = 1'b1;
            start = 1'($urandom_range(0, 1));
            tick;
            start   = 1'b0;
            mem_ack = 1'b0;
            checkOutput("post_err", err, model_err);
            checkOutput("post_cycle", cycle, model_cycle);
            checkOutput("post_strobes", strobes, 0);
            checkOutput("post_done", done, 0);
        end
        checkOutput("end_busy", busy, 0);
        checkOutput("end_addr", mem_addr, model_pc);
    endtask

    // Random program: body of non-END ops followed by an END.
    task automatic applyStimulus(input int nBody);
        logic [7:0] b;
        prog.delete();
        for (int i = 0; i < nBody; i++) begin
            b = 8'($urandom);
            if (b[7:5] == 3'b111) b[7:5] = 3'b110;
            prog.push_back(b);
        end
        b = 8'($urandom);
        b[7:5] = 3'b111;
        prog.push_back(b);
        runProgram(0, 4);
    endtask

    task automatic abortTest;
        start = 1'b1;
        tick;
        start = 1'b0;
        model_err = 1'b0;
        checkOutput("abort_pre_req", mem_req, 1);
        mem_ack = 1'b1;
        abort   = 1'b1;
        in_mem  = 8'h1A;
        tick;
        mem_ack = 1'b0;
        abort   = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_req", mem_req, 0);
        checkOutput("abort_strobes", strobes, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_pc_hold", mem_addr, PC_START);
        checkOutput("abort_err", err, model_err);
        checkOutput("abort_cycle", cycle, model_cycle);
        tick;
        checkOutput("abort_stay_idle", busy, 0);
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        checkOutput("abort_beats_start", busy, 0);
    endtask

    task automatic stallTest;
        start = 1'b1;
        tick;
        start = 1'b0;
`ifdef PARSE_CTRL_WATCHDOG_EN
        for (int w = 0; w < 16; w++) begin
            checkOutput("wd_req", mem_req, 1);
            tick;
        end
        model_err = 1'b1;
        checkOutput("wd_req_drop", mem_req, 0);
        checkOutput("wd_busy", busy, 0);
        checkOutput("wd_err", err, 1);
        checkOutput("wd_done", done, 0);
`else
        for (int w = 0; w < 20; w++) begin
            checkOutput("stall_req", mem_req, 1);
            checkOutput("stall_addr", mem_addr, PC_START);
            tick;
        end
        mem_ack = 1'b1;
        in_mem  = 8'hE0;
        tick;
        mem_ack = 1'b0;
        checkOutput("stall_done", done, 1);
        tick;
        checkOutput("stall_busy", busy, 0);
`endif
    endtask

    task automatic resetMidRun;
        start = 1'b1;
        tick;
        start   = 1'b0;
        mem_ack = 1'b1;
        in_mem  = 8'hC0;
        tick;
        mem_ack = 1'b0;
        tick;
        mem_ack = 1'b1;
        in_mem  = 8'h1A;
        tick;
        mem_ack = 1'b0;
        checkOutput("rst_pre_strobes", strobes, expStrobes(8'h1A, ~model_cycle));
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_async_strobes", strobes, 0);
        checkOutput("rst_async_busy", busy, 0);
        checkOutput("rst_async_req", mem_req, 0);
        checkOutput("rst_async_cycle", cycle, 0);
        checkOutput("rst_async_err", err, 0);
        checkOutput("rst_async_done", done, 0);
        tick;
        reset = 1'b0;
        model_cycle = 1'b0;
        model_err   = 1'b0;
        tick;
    endtask

    initial begin
        #300000;
        miscompares++;
        $display("[TB] FAIL timeout: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        mem_ack = 1'b0;
        in_mem  = 8'h00;
        tick;
        tick;
        checkOutput("reset_req", mem_req, 0);
        checkOutput("reset_addr", mem_addr, 0);
        checkOutput("reset_cycle", cycle, 0);
        checkOutput("reset_strobes", strobes, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_err", err, 0);
        reset = 1'b0;
        tick;
        model_cycle = 1'b0;
        model_err   = 1'b0;

        prog = '{8'h1A, 8'hE0};
        runProgram(0, 0);
        prog = '{8'hC0, 8'h80, 8'hE0};
        runProgram(0, 0);
        prog = '{8'hC0, 8'hE0};
        runProgram(0, 1);
        prog = '{8'hA0, 8'hE0};
        runProgram(0, 1);
        prog = '{8'h55, 8'hE0};
        runProgram(3, 3);
        prog = '{8'h70, 8'h3F, 8'hE0};
        runProgram(0, 2);

        abortTest;
        prog = '{8'h20, 8'hC0, 8'hE0};
        runProgram(0, 2);
        stallTest;
        resetMidRun;

        for (int n = 0; n < 40; n++) begin
            applyStimulus($urandom_range(1, 8));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
